usb3_host_in_xact: RTL and testbench

USB3_HOST_IN_XACT -- requirements
Module: usb3_host_in_xact

---
 rtl/usb3_host_in_xact.sv | 211 +++++++++++++++++++++
 tb/tb_usb3_host_in_xact.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb3_host_in_xact.sv
// USB3 host IN transaction engine: issues ACK TPs requesting data, receives data
// packets, tracks sequence numbers and retries, and reports transfer status.
module usb3_host_in_xact #(
   parameter int unsigned TIMEOUT   = 1000,
   parameter int unsigned MAX_RETRY = 3,
   parameter logic [4:0]  LT_U0     = 5'd16
) (
   input  logic        local_clk,
   input  logic        reset,
   input  logic [4:0]  ltssm_state,
   input  logic        cmd_start,
   input  logic [3:0]  cmd_endp,
   input  logic [4:0]  cmd_nump,
   input  logic [4:0]  cmd_seq,
   output logic        cmd_ready,
   output logic        tx_tp,
   output logic        tx_tp_retry,
   output logic [3:0]  tx_tp_subtype,
   output logic [3:0]  tx_tp_endp,
   output logic [4:0]  tx_tp_nump,
   output logic [4:0]  tx_tp_seq,
   input  logic        tx_tp_ack,
   input  logic        rx_tp,
   input  logic [3:0]  rx_tp_subtype,
   input  logic [3:0]  rx_tp_endp,
   input  logic        rx_dph,
   input  logic [3:0]  rx_dph_endp,
   input  logic [4:0]  rx_dph_seq,
   input  logic [15:0] rx_dph_len,
   input  logic        rx_dpp_start,
   input  logic        rx_dpp_done,
   input  logic        rx_dpp_crcgood,
   output logic        xact_done,
   output logic [15:0] xact_len,
   output logic        xact_err,
   output logic        xact_stall,
   output logic        err_timeout,
   output logic        err_seq
);

   localparam logic [3:0] TP_ACK   = 4'd1;
   localparam logic [3:0] TP_NRDY  = 4'd2;
   localparam logic [3:0] TP_ERDY  = 4'd3;
   localparam logic [3:0] TP_STALL = 4'd5;

   typedef enum logic [3:0] {
      StIdle, StSendReq, StWaitResp, StWaitStart, StWaitDone,
      StSendAck, StWaitErdy, StDone, StError
   } state_e;

   state_e      state_q;
   logic [3:0]  endp_q;
   logic [4:0]  remaining_q;
   logic [4:0]  exp_seq_q;
   logic        retry_q;
   logic [7:0]  retry_cnt_q;
   logic [15:0] len_q;
   logic [31:0] tmo_q;

   logic [16:0] len_sum;
   logic        link_down;
   logic        tmo_hit;
   logic        rx_tp_hit;
   logic        rx_dph_hit;

   assign len_sum    = {1'b0, xact_len} + {1'b0, len_q};
   assign link_down  = (ltssm_state != LT_U0) &&
                       !(state_q inside {StIdle, StDone, StError});
   // WAIT_ERDY is deliberately excluded: the device may hold off indefinitely.
   assign tmo_hit    = (tmo_q == TIMEOUT - 1) &&
                       (state_q inside {StWaitResp, StWaitStart, StWaitDone});
   assign rx_tp_hit  = rx_tp && (rx_tp_endp == endp_q);
   assign rx_dph_hit = rx_dph && (rx_dph_endp == endp_q);

   // Outputs decoded purely from registered state; TP fields read zero when idle.
   assign cmd_ready     = (state_q == StIdle);
   assign tx_tp         = (state_q == StSendReq) || (state_q == StSendAck);
   assign tx_tp_retry   = tx_tp & retry_q;
   assign tx_tp_subtype = tx_tp ? TP_ACK : 4'd0;
   assign tx_tp_endp    = tx_tp ? endp_q : 4'd0;
   assign tx_tp_nump    = tx_tp ? remaining_q : 5'd0;
   assign tx_tp_seq     = tx_tp ? exp_seq_q : 5'd0;
   assign xact_done     = (state_q == StDone);
   assign xact_err      = (state_q == StError);

   // Transaction FSM; every state change also clears the wait-timeout counter.
   always_ff @(posedge local_clk) begin
      if (reset) begin
         state_q     <= StIdle;
         endp_q      <= 4'd0;
         remaining_q <= 5'd0;
         exp_seq_q   <= 5'd0;
         retry_q     <= 1'b0;
         retry_cnt_q <= 8'd0;
         len_q       <= 16'd0;
         tmo_q       <= 32'd0;
         xact_len    <= 16'd0;
         xact_stall  <= 1'b0;
         err_timeout <= 1'b0;
         err_seq     <= 1'b0;
      end else begin
         tmo_q <= tmo_q + 32'd1;
         if (link_down) begin
            state_q <= StError;
            tmo_q   <= 32'd0;
         end else if (tmo_hit) begin
            err_timeout <= 1'b1;
            state_q     <= StError;
            tmo_q       <= 32'd0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (cmd_start) begin
                     endp_q      <= cmd_endp;
                     remaining_q <= cmd_nump;
                     exp_seq_q   <= cmd_seq;
                     retry_q     <= 1'b0;
                     retry_cnt_q <= 8'd0;
                     xact_len    <= 16'd0;
                     xact_stall  <= 1'b0;
                     err_timeout <= 1'b0;
                     err_seq     <= 1'b0;
                     state_q     <= StSendReq;
                     tmo_q       <= 32'd0;
                  end
               end
               StSendReq: begin
                  if (tx_tp_ack) begin
                     state_q <= StWaitResp;
                     tmo_q   <= 32'd0;
                  end
               end
               StWaitResp: begin
                  if (rx_dph_hit) begin
                     if (rx_dph_seq == exp_seq_q) begin
                        len_q   <= rx_dph_len;
                        state_q <= StWaitStart;
                     end else begin
                        err_seq <= 1'b1;
                        retry_q <= 1'b1;
                        state_q <= StSendReq;
                     end
                     tmo_q <= 32'd0;
                  end else if (rx_tp_hit && rx_tp_subtype == TP_NRDY) begin
                     state_q <= StWaitErdy;
                     tmo_q   <= 32'd0;
                  end else if (rx_tp_hit && rx_tp_subtype == TP_STALL) begin
                     xact_stall <= 1'b1;
                     state_q    <= StError;
                     tmo_q      <= 32'd0;
                  end
               end
               StWaitErdy: begin
                  if (rx_tp_hit && rx_tp_subtype == TP_ERDY) begin
                     retry_q <= 1'b0;
                     state_q <= StSendReq;
                     tmo_q   <= 32'd0;
                  end
               end
               StWaitStart: begin
                  if (rx_dpp_start) begin
                     state_q <= StWaitDone;
                     tmo_q   <= 32'd0;
                  end
               end
               StWaitDone: begin
                  if (rx_dpp_done) begin
                     if (rx_dpp_crcgood) begin
                        xact_len    <= len_sum[16] ? 16'hFFFF : len_sum[15:0];
                        exp_seq_q   <= exp_seq_q + 5'd1;
                        remaining_q <= remaining_q - 5'd1;
                        retry_q     <= 1'b0;
                        retry_cnt_q <= 8'd0;
                        state_q     <= StSendAck;
                     end else if (32'(retry_cnt_q) == MAX_RETRY) begin
                        // Out of retries: abort without acknowledging this packet.
                        state_q <= StError;
                     end else begin
                        retry_q     <= 1'b1;
                        retry_cnt_q <= retry_cnt_q + 8'd1;
                        state_q     <= StSendAck;
                     end
                     tmo_q <= 32'd0;
                  end
               end
               StSendAck: begin
                  // The ACK itself requests the next (or retried) packet, so a
                  // continuing transfer waits for data rather than re-requesting.
                  if (tx_tp_ack) begin
                     if (retry_q || (remaining_q != 5'd0 && len_q == 16'd1024)) begin
                        state_q <= StWaitResp;
                     end else begin
                        state_q <= StDone;
                     end
                     tmo_q <= 32'd0;
                  end
               end
               StDone, StError: begin
                  state_q <= StIdle;
                  tmo_q   <= 32'd0;
               end
               default: begin
                  state_q <= StIdle;
                  tmo_q   <= 32'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb3_host_in_xact.sv
// Directed self-checking bench for usb3_host_in_xact.
module tb_usb3_host_in_xact;

   logic        local_clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  ltssm_state = 5'd16;
   logic        cmd_start = 1'b0;
   logic [3:0]  cmd_endp = 4'd0;
   logic [4:0]  cmd_nump = 5'd0;
   logic [4:0]  cmd_seq = 5'd0;
   logic        cmd_ready;
   logic        tx_tp, tx_tp_retry;
   logic [3:0]  tx_tp_subtype, tx_tp_endp;
   logic [4:0]  tx_tp_nump, tx_tp_seq;
   logic        tx_tp_ack = 1'b0;
   logic        rx_tp = 1'b0;
   logic [3:0]  rx_tp_subtype = 4'd0;
   logic [3:0]  rx_tp_endp = 4'd0;
   logic        rx_dph = 1'b0;
   logic [3:0]  rx_dph_endp = 4'd0;
   logic [4:0]  rx_dph_seq = 5'd0;
   logic [15:0] rx_dph_len = 16'd0;
   logic        rx_dpp_start = 1'b0;
   logic        rx_dpp_done = 1'b0;
   logic        rx_dpp_crcgood = 1'b0;
   logic        xact_done, xact_err, xact_stall, err_timeout, err_seq;
   logic [15:0] xact_len;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] cur_endp = 4'd0;

   usb3_host_in_xact dut (
      .local_clk      (local_clk),
      .reset          (reset),
      .ltssm_state    (ltssm_state),
      .cmd_start      (cmd_start),
      .cmd_endp       (cmd_endp),
      .cmd_nump       (cmd_nump),
      .cmd_seq        (cmd_seq),
      .cmd_ready      (cmd_ready),
      .tx_tp          (tx_tp),
      .tx_tp_retry    (tx_tp_retry),
      .tx_tp_subtype  (tx_tp_subtype),
      .tx_tp_endp     (tx_tp_endp),
      .tx_tp_nump     (tx_tp_nump),
      .tx_tp_seq      (tx_tp_seq),
      .tx_tp_ack      (tx_tp_ack),
      .rx_tp          (rx_tp),
      .rx_tp_subtype  (rx_tp_subtype),
      .rx_tp_endp     (rx_tp_endp),
      .rx_dph         (rx_dph),
      .rx_dph_endp    (rx_dph_endp),
      .rx_dph_seq     (rx_dph_seq),
      .rx_dph_len     (rx_dph_len),
      .rx_dpp_start   (rx_dpp_start),
      .rx_dpp_done    (rx_dpp_done),
      .rx_dpp_crcgood (rx_dpp_crcgood),
      .xact_done      (xact_done),
      .xact_len       (xact_len),
      .xact_err       (xact_err),
      .xact_stall     (xact_stall),
      .err_timeout    (err_timeout),
      .err_seq        (err_seq)
   );

   always #5 local_clk = ~local_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge local_clk);
      #1;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return xact_done;
         1:       return xact_err;
         default: return tx_tp;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input int budget, output int cycles);
      cycles = 0;
      while (!sig(sel) && cycles < budget) begin
         tick();
         cycles++;
      end
   endtask

   task automatic start(input logic [3:0] endp, input logic [4:0] nump, input logic [4:0] seq);
      cur_endp  = endp;
      cmd_endp  = endp;
      cmd_nump  = nump;
      cmd_seq   = seq;
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
   endtask

   // Wait for a TP request, check its fields, then accept it.
   task automatic expect_tp(input string tag, input logic retry, input logic [4:0] nump,
                            input logic [4:0] seq);
      int n;
      wait_sig(2, 50, n);
      check_eq({tag, ".tp"}, 32'(tx_tp), 32'd1);
      check_eq({tag, ".sub_endp"}, {24'd0, tx_tp_subtype, tx_tp_endp}, {24'd0, 4'd1, cur_endp});
      check_eq({tag, ".nump"}, 32'(tx_tp_nump), 32'(nump));
      check_eq({tag, ".seq"}, 32'(tx_tp_seq), 32'(seq));
      check_eq({tag, ".retry"}, 32'(tx_tp_retry), 32'(retry));
      tx_tp_ack = 1'b1;
      tick();
      tx_tp_ack = 1'b0;
   endtask

   task automatic send_tp(input logic [3:0] subtype, input logic [3:0] endp);
      rx_tp         = 1'b1;
      rx_tp_subtype = subtype;
      rx_tp_endp    = endp;
      tick();
      rx_tp = 1'b0;
   endtask

   task automatic send_dph(input logic [4:0] seq, input logic [15:0] len);
      rx_dph      = 1'b1;
      rx_dph_endp = cur_endp;
      rx_dph_seq  = seq;
      rx_dph_len  = len;
      tick();
      rx_dph = 1'b0;
   endtask

   task automatic send_dp(input logic [4:0] seq, input logic [15:0] len, input logic crc);
      send_dph(seq, len);
      rx_dpp_start = 1'b1;
      tick();
      rx_dpp_start   = 1'b0;
      rx_dpp_done    = 1'b1;
      rx_dpp_crcgood = crc;
      tick();
      rx_dpp_done    = 1'b0;
      rx_dpp_crcgood = 1'b0;
   endtask

   initial begin
      int n;
      tick();
      tick();
      reset = 1'b0;
      // Reset state
      check_eq("rst.cmd_ready", 32'(cmd_ready), 32'd1);
      check_eq("rst.tx", {26'd0, tx_tp, tx_tp_retry, tx_tp_subtype}, 32'd0);
      check_eq("rst.tx_fields", {22'd0, tx_tp_nump, tx_tp_seq}, 32'd0);
      check_eq("rst.status", {26'd0, xact_done, xact_err, xact_stall, err_timeout, err_seq, 1'b0},
               32'd0);
      check_eq("rst.len", 32'(xact_len), 32'd0);

      // Two full-size packets
      start(4'd1, 5'd2, 5'd0);
      check_eq("t1.busy", 32'(cmd_ready), 32'd0);
      expect_tp("t1.req", 1'b0, 5'd2, 5'd0);
      send_dp(5'd0, 16'd1024, 1'b1);
      expect_tp("t1.ack1", 1'b0, 5'd1, 5'd1);
      send_dp(5'd1, 16'd1024, 1'b1);
      expect_tp("t1.ack2", 1'b0, 5'd0, 5'd2);
      wait_sig(0, 5, n);
      check_eq("t1.done", 32'(xact_done), 32'd1);
      check_eq("t1.len", 32'(xact_len), 32'd2048);
      tick();
      check_eq("t1.done_pulse", 32'(xact_done), 32'd0);
      check_eq("t1.idle", 32'(cmd_ready), 32'd1);

      // NRDY then ERDY, then a short packet
      start(4'd2, 5'd1, 5'd5);
      expect_tp("t2.req", 1'b0, 5'd1, 5'd5);
      send_tp(4'd2, 4'd2);
      repeat (50) tick();
      check_eq("t2.hold", {30'd0, tx_tp, xact_err}, 32'd0);
      send_tp(4'd3, 4'd2);
      expect_tp("t2.rereq", 1'b0, 5'd1, 5'd5);
      send_dp(5'd5, 16'd512, 1'b1);
      expect_tp("t2.ack", 1'b0, 5'd0, 5'd6);
      wait_sig(0, 5, n);
      check_eq("t2.done", 32'(xact_done), 32'd1);
      check_eq("t2.len", 32'(xact_len), 32'd512);
      tick();

      // Four bad CRCs exhaust the retries
      start(4'd3, 5'd1, 5'd0);
      expect_tp("t3.req", 1'b0, 5'd1, 5'd0);
      for (int i = 0; i < 3; i++) begin
         send_dp(5'd0, 16'd1024, 1'b0);
         expect_tp($sformatf("t3.retry%0d", i), 1'b1, 5'd1, 5'd0);
      end
      send_dp(5'd0, 16'd1024, 1'b0);
      wait_sig(1, 5, n);
      check_eq("t3.err", 32'(xact_err), 32'd1);
      check_eq("t3.no_ack", {30'd0, tx_tp, xact_done}, 32'd0);
      tick();
      check_eq("t3.err_pulse", 32'(xact_err), 32'd0);

      // Short packet ends a multi-packet transfer
      start(4'd4, 5'd3, 5'd0);
      expect_tp("t4.req", 1'b0, 5'd3, 5'd0);
      send_dp(5'd0, 16'd100, 1'b1);
      expect_tp("t4.ack", 1'b0, 5'd2, 5'd1);
      wait_sig(0, 5, n);
      check_eq("t4.done", 32'(xact_done), 32'd1);
      check_eq("t4.len", 32'(xact_len), 32'd100);
      tick();

      // Sequence error, then STALL
      start(4'd5, 5'd1, 5'd0);
      expect_tp("t5.req", 1'b0, 5'd1, 5'd0);
      send_dph(5'd3, 16'd64);
      check_eq("t5.err_seq", 32'(err_seq), 32'd1);
      expect_tp("t5.seqretry", 1'b1, 5'd1, 5'd0);
      send_tp(4'd5, 4'd6);
      check_eq("t5.other_endp", {30'd0, xact_err, xact_stall}, 32'd0);
      send_tp(4'd5, 4'd5);
      check_eq("t5.stall", {30'd0, xact_err, xact_stall}, 32'd3);
      tick();
      check_eq("t5.sticky", {30'd0, xact_stall, err_seq}, 32'd3);

      // Link leaves U0 during payload
      start(4'd1, 5'd1, 5'd0);
      check_eq("t6.cleared", {30'd0, xact_stall, err_seq}, 32'd0);
      expect_tp("t6.req", 1'b0, 5'd1, 5'd0);
      send_dph(5'd0, 16'd1024);
      rx_dpp_start = 1'b1;
      tick();
      rx_dpp_start = 1'b0;
      ltssm_state  = 5'd5;
      tick();
      check_eq("t6.link_err", 32'(xact_err), 32'd1);
      ltssm_state = 5'd16;
      tick();

      // Reset while a request is pending
      start(4'd1, 5'd1, 5'd0);
      check_eq("t7.tp_pending", 32'(tx_tp), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("t7.tp_abort", {30'd0, tx_tp, cmd_ready}, 32'd1);
      tick();
      check_eq("t7.quiet", 32'(tx_tp), 32'd0);

      // No response: timeout after exactly TIMEOUT cycles in WAIT_RESP
      start(4'd2, 5'd1, 5'd0);
      expect_tp("t8.req", 1'b0, 5'd1, 5'd0);
      wait_sig(1, 1100, n);
      check_eq("t8.err", 32'(xact_err), 32'd1);
      check_eq("t8.cycles", n, 32'd1000);
      check_eq("t8.timeout", 32'(err_timeout), 32'd1);
      tick();
      check_eq("t8.sticky", {30'd0, err_timeout, cmd_ready}, 32'd3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
